uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter between NUM_REQ byte-stream requesters. The block runs round-robin arbitration, locks the grant for a message burst, and issues one byte at a time using the transmitter's enable/busy handshake. It sits between the application sources and the transmitter's `i_txdata`/`i_tx_enable`/`o_busy` ports.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: byte width; must match the transmitter.
- MAX_BURST, 16: maximum bytes per grant before a forced release.
- WDOG_CYCLES, 32: watchdog limit in cycles (used only with UART_ARB_WDOG_EN).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  NUM_REQ  requester r has a valid byte.
- i_data  in  NUM_REQ*DATA_WIDTH  byte for requester r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- i_last  in  NUM_REQ  the current byte of requester r ends its message.
- o_ack  out  NUM_REQ  one-cycle pulse: byte of requester r consumed; the requester presents the next byte or drops i_req.
- o_grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- o_txdata  out  DATA_WIDTH  byte to the transmitter; held until the next issue.
- o_tx_enable  out  1  one-cycle pulse to the transmitter.
- i_tx_busy  in  1  transmitter busy.
- o_wdog_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- All outputs are registered. Reset values: o_ack=0, o_grant=0, o_txdata=0, o_tx_enable=0, o_wdog_err=0. Internal reset values: rr pointer=0, burst count=0, state IDLE.
- IDLE: if |i_req, select the first requester with i_req high, searching upward from the pointer modulo NUM_REQ. Latch its index g, set o_grant to one-hot(g), and clear the burst count. Next state is ISSUE.
- ISSUE, if i_req[g]=1:
  - Register o_txdata<=i_data[g], o_tx_enable<=1, and o_ack[g]<=1, each for exactly one cycle.
  - Latch i_last[g] and increment the burst count.
  - Next state is WAIT_BUSY.
- ISSUE, if i_req[g]=0: release the grant and go to IDLE.
- WAIT_BUSY: wait for i_tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for i_tx_busy=0.
  - If the latched last=1 or burst count==MAX_BURST, release the grant and go to IDLE.
  - Otherwise go to ISSUE.
- Release: o_grant<=0 and pointer<=(g+1) mod NUM_REQ. This gives a fair rotation after every burst.
- A requester's i_req going low during WAIT_* has no effect until the next ISSUE.
- The burst count width is $clog2(MAX_BURST+1). It must not wrap, because the release at MAX_BURST happens first.
- Requests from other requesters during a grant are ignored. Lower-priority requesters are never reordered within a scan.

## Timing
- Arbitration to first enable: request seen in IDLE at edge n, grant at n+1, o_tx_enable and o_ack high during cycle n+2.
- The transmitter raises busy one cycle after enable. WAIT_BUSY therefore normally lasts 1–2 cycles.
- Inter-byte gap in a burst: the enable for byte k+1 is issued 2 cycles after i_tx_busy falls (WAIT_DONE→ISSUE→pulse).
- Grant release to the next grant: 2 cycles (IDLE, then arbitration).
- Simultaneous requests at reset release: requester 0 wins; after its release, requester 1 wins.
- Reset mid-burst: all outputs go to their reset values at the next edge. The in-flight byte may still finish on the line, and no ack is reissued.

## Configuration
- UART_ARB_WDOG_EN defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE and clears on every state change.
  - Reaching WDOG_CYCLES pulses o_wdog_err, releases the grant, and returns to IDLE.
- UART_ARB_WDOG_EN undefined: there is no watchdog logic, o_wdog_err is tied 0, and the arbiter waits indefinitely.

## Test plan
- Single byte: i_req=4'b0001, i_data[7:0]=8'hA5, i_last[0]=1 → one o_tx_enable pulse with o_txdata=8'hA5, one o_ack[0], o_grant returns to 0 after busy falls, and the pointer becomes 1.
- Burst lock: requester 2 sends 3 bytes 8'h10, 8'h11, 8'h12 (last on third) while requester 0 also requests → all three bytes go out before o_grant=4'b0001.
- Round robin: all four requesters hold i_req with i_last=1 → grant order 0,1,2,3,0.
- MAX_BURST=4 with requester 1 never asserting last and requester 3 waiting → after the 4th ack the grant moves to 3, then back to 1.
- Request withdrawal: requester 0 drops i_req after its first ack, with i_last=0 → ISSUE releases and no extra enable is issued.
- Watchdog (macro defined): i_tx_busy stuck 0 after enable → o_wdog_err pulses WDOG_CYCLES cycles later and o_grant=0. Mid-burst rst → all outputs are 0 next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, burst-locked sharing of one UART transmitter among
//            NUM_REQ byte-stream requesters. Optional watchdog: UART_ARB_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 16,
    parameter int WDOG_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]            i_last,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_txdata,
    output logic                          o_tx_enable,
    input  logic                          i_tx_busy,
    output logic                          o_wdog_err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_g;
    logic [BURST_W-1:0] r_burst;
    logic               r_last;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W:0]     w_cand;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [DATA_WIDTH-1:0] w_data;

    // Scan upward from the pointer, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (r_g == IDX_W'(r)) begin
                w_data = i_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_next = (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;

`ifdef UART_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              w_wait;
    logic              w_wait_exit;
    logic              w_wdog_abort;

    assign w_wait       = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_wait_exit  = ((r_state == S_WAIT_BUSY) &&  i_tx_busy) ||
                          ((r_state == S_WAIT_DONE) && !i_tx_busy);
    // A normal exit takes priority over an abort landing on the same cycle.
    assign w_wdog_abort = w_wait && !w_wait_exit &&
                          (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog     <= '0;
            o_wdog_err <= 1'b0;
        end else begin
            o_wdog_err <= w_wdog_abort;
            if (!w_wait || w_wait_exit || w_wdog_abort) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end
`else
    assign o_wdog_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_burst     <= '0;
            r_last      <= 1'b0;
            o_ack       <= '0;
            o_grant     <= '0;
            o_txdata    <= '0;
            o_tx_enable <= 1'b0;
        end else begin
            o_ack       <= '0;
            o_tx_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_g     <= w_sel;
                        o_grant <= NUM_REQ'(1) << w_sel;
                        r_burst <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_req[r_g]) begin
                        o_txdata    <= w_data;
                        o_tx_enable <= 1'b1;
                        o_ack       <= NUM_REQ'(1) << r_g;
                        r_last      <= i_last[r_g];
                        r_burst     <= r_burst + 1'b1;
                        r_state     <= S_WAIT_BUSY;
                    end else begin
                        o_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (r_last || (r_burst == BURST_W'(MAX_BURST))) begin
                            o_grant <= '0;
                            r_ptr   <= w_ptr_next;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef UART_ARB_WDOG_EN
            if (w_wdog_abort) begin
                o_grant <= '0;
                r_ptr   <= w_ptr_next;
                r_state <= S_IDLE;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter (MAX_BURST overridden to 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int WDOG = 32;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   i_req;
    logic [NR*DW-1:0] i_data;
    logic [NR-1:0]   i_last;
    logic [NR-1:0]   o_ack;
    logic [NR-1:0]   o_grant;
    logic [DW-1:0]   o_txdata;
    logic            o_tx_enable;
    logic            i_tx_busy;
    logic            o_wdog_err;

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .WDOG_CYCLES(WDOG)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_txdata   (o_txdata),
        .o_tx_enable(o_tx_enable),
        .i_tx_busy  (i_tx_busy),
        .o_wdog_err (o_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected issue order: {requester index, byte}
    logic [9:0] exp_q[$];

    logic [8:0] rmem [NR][16];
    int         rhead[NR];
    int         rtail[NR];
    logic       tx_stuck;
    logic       wdog_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        rmem[r][rtail[r]] = {l, d};
        rtail[r]++;
    endtask

    task automatic push_exp(input logic [1:0] r, input logic [7:0] d);
        exp_q.push_back({r, d});
    endtask

    // Requester model: present the head byte, advance on ack.
    initial begin
        i_req  = '0;
        i_data = '0;
        i_last = '0;
        for (int r = 0; r < NR; r++) begin
            rhead[r] = 0;
            rtail[r] = 0;
        end
        forever begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (o_ack[r] && rhead[r] < rtail[r]) rhead[r]++;
                if (rhead[r] < rtail[r]) begin
                    i_req[r]          = 1'b1;
                    i_data[r*DW +: DW] = rmem[r][rhead[r]][7:0];
                    i_last[r]         = rmem[r][rhead[r]][8];
                end else begin
                    i_req[r]  = 1'b0;
                    i_last[r] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy rises one cycle after enable, lasts 3 cycles.
    initial begin
        int  busy_cnt;
        logic pend;
        busy_cnt  = 0;
        pend      = 1'b0;
        i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                i_tx_busy = 1'b1;
                busy_cnt  = 3;
                pend      = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) i_tx_busy = 1'b0;
            end
            if (o_tx_enable && !tx_stuck) pend = 1'b1;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [9:0]    e;
        logic [NR-1:0] oh;
        wdog_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_wdog_err) wdog_seen = 1'b1;
                if (o_tx_enable) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_enable: got data %0h grant %b, expected no issue",
                                 o_txdata, o_grant);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 4'b0001 << e[9:8];
                        chk("tx_data", 32'(o_txdata), 32'(e[7:0]));
                        chk("grant_at_issue", 32'(o_grant), 32'(oh));
                        chk("ack_at_issue", 32'(o_ack), 32'(oh));
                    end
                end else if (o_ack != '0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ack_without_enable: got ack %b expected 0", o_ack);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"},   32'(o_ack), 32'd0);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_txdata"}, 32'(o_txdata), 32'd0);
        chk({tag, "_txen"},  32'(o_tx_enable), 32'd0);
        chk({tag, "_wdog"},  32'(o_wdog_err), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || o_grant != '0) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        if (cyc >= 500) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d cycles expected < 500", name, cyc);
            exp_q.delete();
        end
        repeat (12) @(negedge clk);
        chk({name, "_grant_idle"}, 32'(o_grant), 32'd0);
        for (int r = 0; r < NR; r++) begin
            rhead[r] = 0;
            rtail[r] = 0;
        end
    endtask

    task automatic wait_enable(input string name);
        int cyc;
        cyc = 0;
        while (!o_tx_enable && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_no_enable: got none expected enable within 100 cycles", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        tx_stuck = 1'b0;
        do_reset();

        // Single byte from requester 0; pointer then moves to 1.
        load(0, 8'hA5, 1'b1);
        push_exp(2'd0, 8'hA5);
        wait_idle("single");

        // Burst lock: pointer=1 so requester 2 wins and keeps the grant.
        load(2, 8'h10, 1'b0); load(2, 8'h11, 1'b0); load(2, 8'h12, 1'b1);
        load(0, 8'hB0, 1'b1);
        push_exp(2'd2, 8'h10); push_exp(2'd2, 8'h11); push_exp(2'd2, 8'h12);
        push_exp(2'd0, 8'hB0);
        wait_idle("burst_lock");

        // Round robin from a fresh pointer: 0,1,2,3,0.
        do_reset();
        load(0, 8'hC0, 1'b1); load(0, 8'hC4, 1'b1);
        load(1, 8'hC1, 1'b1); load(2, 8'hC2, 1'b1); load(3, 8'hC3, 1'b1);
        push_exp(2'd0, 8'hC0); push_exp(2'd1, 8'hC1); push_exp(2'd2, 8'hC2);
        push_exp(2'd3, 8'hC3); push_exp(2'd0, 8'hC4);
        wait_idle("round_robin");

        // MAX_BURST=4: requester 1 cut after 4 bytes, 3 served, then 1 resumes.
        for (int i = 0; i < 6; i++) load(1, 8'h20 + 8'(i), 1'b0);
        load(3, 8'h30, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(2'd1, 8'h20 + 8'(i));
        push_exp(2'd3, 8'h30);
        push_exp(2'd1, 8'h24); push_exp(2'd1, 8'h25);
        wait_idle("max_burst");

        // Withdrawal: one byte without last, then i_req drops.
        load(0, 8'h40, 1'b0);
        push_exp(2'd0, 8'h40);
        wait_idle("withdraw");

        // Reset in the middle of a burst.
        load(2, 8'h50, 1'b0); load(2, 8'h51, 1'b0); load(2, 8'h52, 1'b1);
        push_exp(2'd2, 8'h50);
        wait_enable("mid_reset");
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            rhead[r] = 0;
            rtail[r] = 0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_reset_drained", 32'(exp_q.size()), 32'd0);
        chk("mid_reset_idle", 32'(o_grant), 32'd0);

`ifdef UART_ARB_WDOG_EN
        begin
            int cyc;
            tx_stuck = 1'b1;
            load(0, 8'h55, 1'b1);
            push_exp(2'd0, 8'h55);
            wait_enable("wdog");
            cyc = 0;
            while (!o_wdog_err && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("wdog_latency", 32'(cyc), 32'(WDOG));
            chk("wdog_grant", 32'(o_grant), 32'd0);
            @(negedge clk);
            chk("wdog_pulse_width", 32'(o_wdog_err), 32'd0);
            tx_stuck = 1'b0;
            wait_idle("wdog");
        end
`else
        chk("wdog_never", 32'(wdog_seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
